key_requester: RTL and testbench

- Requester side of the key-check interface: accepts a user code and builds the 8-bit key with an even-parity bit.
- Presents the key to the access controller, holds it stable, then samples the controller's grant response.
- Tracks consecutive denials and enforces a timed lockout after too many failures.
- Sits between the keypad/entry logic and the access controller.

---
 rtl/key_requester.sv | 149 ++++++++++++++
 tb/tb_key_requester.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_requester.sv
// rtl/key_requester.sv - requester side of the key-check interface with parity key build and lockout
module key_requester #(
    parameter int CODE_W         = 7,
    parameter int RESP_LAT       = 3,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             code_valid,
    input  logic [CODE_W-1:0]                code,
    output logic                             code_ready,
    output logic [CODE_W:0]                  key,
    output logic                             key_valid,
    input  logic                             access_granted,
    output logic                             done,
    output logic                             granted,
    output logic                             rejected,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int FW      = $clog2(MAX_TRIES + 1);
    localparam int CNT_MAX = (RESP_LAT > LOCKOUT_CYCLES) ? RESP_LAT : LOCKOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PRESENT_LAST = CW'(RESP_LAT - 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_LOCKOUT
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [CODE_W:0]   key_nxt;
    logic              key_valid_nxt;
    logic              done_nxt;
    logic              granted_nxt;
    logic              rejected_nxt;
    logic              locked_nxt;
    logic [FW-1:0]     fail_nxt;
    logic [FW-1:0]     fail_inc;
    logic              accept;

    // Gating with rst keeps code_ready low for the whole time reset is held.
    assign code_ready = (state == S_IDLE) && rst;
    assign accept     = code_valid && code_ready;
    assign fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            key        <= '0;
            key_valid  <= 1'b0;
            done       <= 1'b0;
            granted    <= 1'b0;
            rejected   <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            key        <= key_nxt;
            key_valid  <= key_valid_nxt;
            done       <= done_nxt;
            granted    <= granted_nxt;
            rejected   <= rejected_nxt;
            locked_out <= locked_nxt;
            fail_cnt   <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_nxt       = key;
        key_valid_nxt = key_valid;
        done_nxt      = 1'b0;
        granted_nxt   = granted;
        rejected_nxt  = rejected;
        locked_nxt    = locked_out;
        fail_nxt      = fail_cnt;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (code == '0) begin
                        // The controller ignores an all-zero key, so finish locally.
                        done_nxt     = 1'b1;
                        rejected_nxt = 1'b1;
                        granted_nxt  = 1'b0;
                    end else begin
                        key_nxt       = {^code, code};
                        key_valid_nxt = 1'b1;
                        rejected_nxt  = 1'b0;
                        cnt_nxt       = '0;
                        state_nxt     = S_PRESENT;
                    end
                end
            end

            S_PRESENT: begin
                if (cnt == PRESENT_LAST) begin
                    key_nxt       = '0;
                    key_valid_nxt = 1'b0;
                    done_nxt      = 1'b1;
                    granted_nxt   = access_granted;
                    cnt_nxt       = '0;
                    if (access_granted) begin
                        fail_nxt  = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        fail_nxt = fail_inc;
                        if (fail_inc == FAIL_MAX) begin
                            locked_nxt = 1'b1;
                            state_nxt  = S_LOCKOUT;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            S_LOCKOUT: begin
                if (cnt == LOCK_LAST) begin
                    locked_nxt = 1'b0;
                    fail_nxt   = '0;
                    cnt_nxt    = '0;
                    state_nxt  = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_requester.sv
// tb/tb_key_requester.sv - randomized self-checking bench for key_requester
module tb_key_requester;

    localparam int CODE_W         = 7;
    localparam int RESP_LAT       = 3;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int FW             = $clog2(MAX_TRIES + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              code_valid = 1'b0;
    logic [CODE_W-1:0] code = '0;
    logic              code_ready;
    logic [CODE_W:0]   key;
    logic              key_valid;
    logic              access_granted = 1'b0;
    logic              done;
    logic              granted;
    logic              rejected;
    logic              locked_out;
    logic [FW-1:0]     fail_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    int m_fail     = 0;
    bit m_granted  = 0;
    bit m_rejected = 0;

    key_requester #(
        .CODE_W(CODE_W), .RESP_LAT(RESP_LAT),
        .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
        .code_ready(code_ready), .key(key), .key_valid(key_valid),
        .access_granted(access_granted), .done(done), .granted(granted),
        .rejected(rejected), .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Parity bit chosen so the key has an even number of ones.
    function automatic logic [CODE_W:0] ref_key(input logic [CODE_W-1:0] c);
        int ones = $countones(c);
        logic [CODE_W:0] k = (CODE_W+1)'(c);
        if (ones % 2 == 1) k = k + (CODE_W+1)'(1 << CODE_W);
        return k;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_code_ready"}, code_ready, 0);
        chk({tag, "_key"}, key, 0);
        chk({tag, "_key_valid"}, key_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_granted"}, granted, 0);
        chk({tag, "_rejected"}, rejected, 0);
        chk({tag, "_locked"}, locked_out, 0);
        chk({tag, "_fail_cnt"}, fail_cnt, 0);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!code_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!code_ready) chk("ready_timeout", 0, 1);
    endtask

    // One attempt, called at a negedge; returns at the negedge of the last checked cycle.
    task automatic attempt(input logic [CODE_W-1:0] c, input bit g, input bit stop_at_lock);
        bit lock;
        wait_ready();
        code_valid = 1'b1;
        code       = c;
        @(negedge clk);
        code_valid = 1'b0;
        if (c == '0) begin
            m_rejected = 1;
            m_granted  = 0;
            chk("zero_done", done, 1);
            chk("zero_rejected", rejected, 1);
            chk("zero_granted", granted, 0);
            chk("zero_key_valid", key_valid, 0);
            chk("zero_fail_cnt", fail_cnt, m_fail);
            return;
        end
        chk("granted_hold", granted, m_granted);
        chk("rejected_clear", rejected, 0);
        for (int k = 1; k <= RESP_LAT; k++) begin
            if (k > 1) @(negedge clk);
            chk("key_valid", key_valid, 1);
            chk("key", key, ref_key(c));
            chk("key_parity", $countones(key) % 2, 0);
            chk("ready_while_key", code_ready, 0);
            chk("done_early", done, 0);
            access_granted = (k == RESP_LAT) ? g : 1'($urandom);
        end
        @(negedge clk);
        access_granted = 1'($urandom);
        if (g) m_fail = 0;
        else if (m_fail < MAX_TRIES) m_fail++;
        m_granted  = g;
        m_rejected = 0;
        lock = (m_fail == MAX_TRIES);
        chk("done", done, 1);
        chk("granted", granted, g);
        chk("key_valid_end", key_valid, 0);
        chk("key_end", key, 0);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("locked_out", locked_out, lock);
        if (!lock || stop_at_lock) return;
        for (int j = 2; j <= LOCKOUT_CYCLES; j++) begin
            @(negedge clk);
            chk("lock_active", locked_out, 1);
            chk("lock_ready", code_ready, 0);
            chk("lock_done", done, 0);
            chk("lock_key_valid", key_valid, 0);
            chk("lock_fail_cnt", fail_cnt, MAX_TRIES);
            code_valid = 1'($urandom);
            code       = CODE_W'($urandom);
        end
        @(negedge clk);
        code_valid = 1'b0;
        m_fail = 0;
        chk("unlock_ready", code_ready, 1);
        chk("unlock_locked", locked_out, 0);
        chk("unlock_fail_cnt", fail_cnt, 0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_all_zero(tag);
        m_fail = 0; m_granted = 0; m_rejected = 0;
        code_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_after"}, code_ready, 1);
        chk({tag, "_no_done"}, done, 0);
        chk({tag, "_no_key"}, key_valid, 0);
    endtask

    initial begin
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", code_ready, 1);

        attempt(7'h03, 1, 0);
        attempt(7'h01, 1, 0);
        attempt(7'h7F, 1, 0);
        for (int c = 1; c < 128; c++) attempt(CODE_W'(c), 1, 0);

        attempt(7'h05, 0, 0);
        attempt(7'h06, 0, 0);
        attempt(7'h07, 0, 0);

        attempt(7'h11, 0, 0);
        attempt(7'h12, 0, 0);
        attempt(7'h13, 1, 0);
        chk("no_lock_after_grant", locked_out, 0);

        attempt(7'h21, 0, 0);
        attempt(7'h00, 0, 0);
        attempt(7'h00, 0, 0);
        attempt(7'h22, 1, 0);

        // Back-to-back: code_valid held high across done.
        wait_ready();
        code_valid = 1'b1;
        code = 7'h15;
        access_granted = 1'b1;
        for (int k = 1; k <= RESP_LAT + 2; k++) begin
            @(negedge clk);
            if (k == RESP_LAT + 1) begin
                chk("b2b_done", done, 1);
                chk("b2b_ready", code_ready, 1);
            end
            if (k == RESP_LAT + 2) begin
                chk("b2b_reaccept", key_valid, 1);
                chk("b2b_single_done", done, 0);
                code_valid = 1'b0;
            end
        end
        begin
            int t = 0;
            while (!done && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_second_done", done, 1);
            chk("b2b_second_granted", granted, 1);
        end
        m_fail = 0; m_granted = 1; m_rejected = 0;
        access_granted = 1'b0;
        @(negedge clk);

        // Reset in the middle of a presentation.
        wait_ready();
        code_valid = 1'b1;
        code = 7'h2A;
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
        chk("mid_present_kv", key_valid, 1);
        async_reset("rst_present");

        // Reset in the middle of a lockout.
        attempt(7'h31, 0, 0);
        attempt(7'h32, 0, 0);
        attempt(7'h33, 0, 1);
        repeat (3) @(negedge clk);
        chk("mid_lock_active", locked_out, 1);
        async_reset("rst_lock");

        for (int i = 0; i < 60; i++) begin
            logic [CODE_W-1:0] c;
            c = ($urandom % 6 == 0) ? '0 : CODE_W'($urandom);
            attempt(c, 1'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
